// File: rtl/nqueen_pkg.sv
// Shared types and helpers for the N-queens search engine.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nqueen_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLACE     = 3'd1,
        S_BACKTRACK = 3'd2,
        S_EMIT      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Bits needed to hold a row/column index, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // Rising diagonal: constant along r+c.
    function automatic int diag1_idx(input int r, input int c);
        return r + c;
    endfunction

    // Falling diagonal: constant along r-c, shifted so the index is never negative.
    function automatic int diag2_idx(input int r, input int c, input int n);
        return r - c + n - 1;
    endfunction

endpackage

// File: rtl/nqueen_if.sv
// Control and solution-stream bundle of the N-queens engine.
// Latency: n/a (wires only).
// Backpressure: solution stream is valid/ready; sol_row is held while sol_valid & !sol_ready.
interface nqueen_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    localparam int ROW_W = nqueen_pkg::clog2_min1(N);

    logic                 start;
    logic                 mode;
    logic                 abort;
    logic                 sol_valid;
    logic                 sol_ready;
    logic [N*ROW_W-1:0]   sol_row;
    logic [CNT_W-1:0]     sol_count;
    logic                 busy;
    logic                 done;

    // master: the controller/consumer side; slave: the solver.
    modport master (
        output start, mode, abort, sol_ready,
        input  sol_valid, sol_row, sol_count, busy, done
    );

    modport slave (
        input  start, mode, abort, sol_ready,
        output sol_valid, sol_row, sol_count, busy, done
    );

endinterface

// File: rtl/nqueen_occupancy.sv
// Row and diagonal occupancy masks with a combinational free() probe.
// Latency: set/clear visible one cycle after the strobe; free is combinational.
// Backpressure: none; one set or clear per cycle, clr_all has priority.
// Ports: clr_all wipes all masks; set_en/clr_en write the three bits for (op_r,op_c);
//        free reports whether (probe_r,probe_c) is unattacked.
module nqueen_occupancy
    import nqueen_pkg::*;
#(
    parameter int N     = 8,
    parameter int ROW_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_all,
    input  logic             set_en,
    input  logic             clr_en,
    input  logic [ROW_W-1:0] op_r,
    input  logic [ROW_W-1:0] op_c,
    input  logic [ROW_W-1:0] probe_r,
    input  logic [ROW_W-1:0] probe_c,
    output logic             free
);
    // One extra bit holds diagonal indices up to 2N-2.
    localparam int D_W = ROW_W + 1;
    localparam int ND  = 2 * N - 1;

    logic [N-1:0]   rowm;
    logic [ND-1:0]  d1m;
    logic [ND-1:0]  d2m;
    logic [D_W-1:0] op_d1, op_d2, pr_d1, pr_d2;
    logic           row_hit, d1_hit, d2_hit;

    assign op_d1 = D_W'(diag1_idx(int'(op_r), int'(op_c)));
    assign op_d2 = D_W'(diag2_idx(int'(op_r), int'(op_c), N));
    assign pr_d1 = D_W'(diag1_idx(int'(probe_r), int'(probe_c)));
    assign pr_d2 = D_W'(diag2_idx(int'(probe_r), int'(probe_c), N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowm <= '0;
            d1m  <= '0;
            d2m  <= '0;
        end else if (clr_all) begin
            rowm <= '0;
            d1m  <= '0;
            d2m  <= '0;
        end else if (set_en || clr_en) begin
            for (int i = 0; i < N; i++)
                if (op_r == ROW_W'(i)) rowm[i] <= set_en;
            for (int i = 0; i < ND; i++) begin
                if (op_d1 == D_W'(i)) d1m[i] <= set_en;
                if (op_d2 == D_W'(i)) d2m[i] <= set_en;
            end
        end
    end

    // Decoded compares keep every index in range for non-power-of-two N.
    always_comb begin
        row_hit = 1'b0;
        d1_hit  = 1'b0;
        d2_hit  = 1'b0;
        for (int i = 0; i < N; i++)
            if (rowm[i] && probe_r == ROW_W'(i)) row_hit = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (d1m[i] && pr_d1 == D_W'(i)) d1_hit = 1'b1;
            if (d2m[i] && pr_d2 == D_W'(i)) d2_hit = 1'b1;
        end
        free = !(row_hit || d1_hit || d2_hit);
    end

endmodule

// File: rtl/nqueen_solver.sv
// N-queens backtracking search, one row probe per clock, streaming each solution.
// Latency: busy the cycle after start; each solution held on sol_row until accepted.
// Backpressure: search stalls in EMIT while sol_ready is low; abort always wins.
// Ports: clk, rst_n (async active-low); bus (slave): start/mode/abort in,
//        sol_valid/sol_ready/sol_row stream, sol_count, busy, done status.
module nqueen_solver
    import nqueen_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    nqueen_if.slave  bus
);
    localparam int ROW_W = clog2_min1(N);
    // Probe row runs 0..N inclusive; N means the column is exhausted.
    localparam int R_W = ROW_W + 1;
    localparam logic [ROW_W-1:0] LAST_C = ROW_W'(N - 1);

    state_t           state, state_nxt;
    logic [ROW_W-1:0] c;
    logic [R_W-1:0]   r;
    logic [ROW_W-1:0] pos [N];
    logic             mode_q;
    logic [CNT_W-1:0] cnt;

    logic             free, r_ok, hs;
    logic [ROW_W-1:0] c_m1, prev_pos;
    logic             occ_clr_all, occ_set, occ_clr;
    logic [ROW_W-1:0] op_r, op_c;

    assign r_ok = (r < R_W'(N));
    assign hs   = (state == S_EMIT) && bus.sol_ready;
    assign c_m1 = c - ROW_W'(1);

    always_comb begin
        prev_pos = '0;
        for (int i = 0; i < N; i++)
            if (c_m1 == ROW_W'(i)) prev_pos = pos[i];
    end

    nqueen_occupancy #(.N(N), .ROW_W(ROW_W)) u_occ (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_all (occ_clr_all),
        .set_en  (occ_set),
        .clr_en  (occ_clr),
        .op_r    (op_r),
        .op_c    (op_c),
        .probe_r (r[ROW_W-1:0]),
        .probe_c (c),
        .free    (free)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        occ_clr_all = 1'b0;
        occ_set     = 1'b0;
        occ_clr     = 1'b0;
        op_r        = r[ROW_W-1:0];
        op_c        = c;
        if (bus.abort) begin
            state_nxt   = S_IDLE;
            occ_clr_all = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_nxt   = S_PLACE;
                        occ_clr_all = 1'b1;
                    end
                end
                S_PLACE: begin
                    if (!r_ok) begin
                        state_nxt = S_BACKTRACK;
                    end else if (free) begin
                        occ_set = 1'b1;
                        if (c == LAST_C) state_nxt = S_EMIT;
                    end
                end
                S_BACKTRACK: begin
                    if (c == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_PLACE;
                        occ_clr   = 1'b1;
                        op_r      = prev_pos;
                        op_c      = c_m1;
                    end
                end
                S_EMIT: begin
                    if (hs) begin
                        if (mode_q) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_PLACE;
                            occ_clr   = 1'b1;
                            op_r      = pos[N-1];
                            op_c      = LAST_C;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c      <= '0;
            r      <= '0;
            pos    <= '{default: '0};
            mode_q <= 1'b0;
            cnt    <= '0;
        end else if (!bus.abort) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        c      <= '0;
                        r      <= '0;
                        cnt    <= '0;
                        mode_q <= bus.mode;
                    end
                end
                S_PLACE: begin
                    if (r_ok) begin
                        if (free) begin
                            for (int i = 0; i < N; i++)
                                if (c == ROW_W'(i)) pos[i] <= r[ROW_W-1:0];
                            // The last column stays put so EMIT can resume from it.
                            if (c != LAST_C) begin
                                c <= c + ROW_W'(1);
                                r <= '0;
                            end
                        end else begin
                            r <= r + R_W'(1);
                        end
                    end
                end
                S_BACKTRACK: begin
                    if (c != '0) begin
                        c <= c_m1;
                        r <= R_W'(prev_pos) + R_W'(1);
                    end
                end
                S_EMIT: begin
                    if (hs) begin
                        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                        if (!mode_q) r <= R_W'(pos[N-1]) + R_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.sol_row = '0;
        for (int i = 0; i < N; i++)
            bus.sol_row[i*ROW_W +: ROW_W] = pos[i];
    end

    assign bus.sol_valid = (state == S_EMIT);
    assign bus.busy      = (state == S_PLACE) || (state == S_BACKTRACK) || (state == S_EMIT);
    assign bus.done      = (state == S_DONE);
    assign bus.sol_count = cnt;

endmodule

// File: tb/tb_nqueen_solver.sv
module tb_nqueen_solver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic g_start, g_mode, g_abort, g_ready;
    int   sel;
    int   cur_n, cur_w;
    int   total = 0;
    int   bad   = 0;

    nqueen_if #(.N(8), .CNT_W(16)) i8 ();
    nqueen_if #(.N(4), .CNT_W(16)) i4 ();
    nqueen_if #(.N(3), .CNT_W(16)) i3 ();
    nqueen_if #(.N(1), .CNT_W(16)) i1 ();
    nqueen_if #(.N(6), .CNT_W(3))  i6 ();
    nqueen_if #(.N(5), .CNT_W(3))  i5 ();

    nqueen_solver #(.N(8), .CNT_W(16)) d8 (.clk(clk), .rst_n(rst_n), .bus(i8));
    nqueen_solver #(.N(4), .CNT_W(16)) d4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    nqueen_solver #(.N(3), .CNT_W(16)) d3 (.clk(clk), .rst_n(rst_n), .bus(i3));
    nqueen_solver #(.N(1), .CNT_W(16)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    nqueen_solver #(.N(6), .CNT_W(3))  d6 (.clk(clk), .rst_n(rst_n), .bus(i6));
    nqueen_solver #(.N(5), .CNT_W(3))  d5 (.clk(clk), .rst_n(rst_n), .bus(i5));

    assign i8.start = g_start && (sel == 0);
    assign i8.abort = g_abort && (sel == 0);
    assign i8.mode = g_mode;
    assign i8.sol_ready = g_ready;
    assign i4.start = g_start && (sel == 1);
    assign i4.abort = g_abort && (sel == 1);
    assign i4.mode = g_mode;
    assign i4.sol_ready = g_ready;
    assign i3.start = g_start && (sel == 2);
    assign i3.abort = g_abort && (sel == 2);
    assign i3.mode = g_mode;
    assign i3.sol_ready = g_ready;
    assign i1.start = g_start && (sel == 3);
    assign i1.abort = g_abort && (sel == 3);
    assign i1.mode = g_mode;
    assign i1.sol_ready = g_ready;
    assign i6.start = g_start && (sel == 4);
    assign i6.abort = g_abort && (sel == 4);
    assign i6.mode = g_mode;
    assign i6.sol_ready = g_ready;
    assign i5.start = g_start && (sel == 5);
    assign i5.abort = g_abort && (sel == 5);
    assign i5.mode = g_mode;
    assign i5.sol_ready = g_ready;

    logic        m_vld, m_busy, m_done;
    logic [63:0] m_row, m_cnt;

    always_comb begin
        m_vld = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_row = '0; m_cnt = '0;
        case (sel)
            0: begin m_vld = i8.sol_valid; m_busy = i8.busy; m_done = i8.done; m_row = 64'(i8.sol_row); m_cnt = 64'(i8.sol_count); end
            1: begin m_vld = i4.sol_valid; m_busy = i4.busy; m_done = i4.done; m_row = 64'(i4.sol_row); m_cnt = 64'(i4.sol_count); end
            2: begin m_vld = i3.sol_valid; m_busy = i3.busy; m_done = i3.done; m_row = 64'(i3.sol_row); m_cnt = 64'(i3.sol_count); end
            3: begin m_vld = i1.sol_valid; m_busy = i1.busy; m_done = i1.done; m_row = 64'(i1.sol_row); m_cnt = 64'(i1.sol_count); end
            4: begin m_vld = i6.sol_valid; m_busy = i6.busy; m_done = i6.done; m_row = 64'(i6.sol_row); m_cnt = 64'(i6.sol_count); end
            5: begin m_vld = i5.sol_valid; m_busy = i5.busy; m_done = i5.done; m_row = 64'(i5.sol_row); m_cnt = 64'(i5.sol_count); end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic select(input int k, input int n, input int w);
        sel = k; cur_n = n; cur_w = w;
        #1;
    endtask

    function automatic logic [63:0] pack(input int p[8], input int n, input int w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(p[i]) << (i * w));
        return v;
    endfunction

    function automatic bit legal(input logic [63:0] row, input int n, input int w);
        int p[16];
        for (int i = 0; i < n; i++) p[i] = int'((row >> (i * w)) & ((64'd1 << w) - 64'd1));
        for (int a = 0; a < n; a++) begin
            if (p[a] >= n) return 1'b0;
            for (int b = a + 1; b < n; b++)
                if (p[a] == p[b] || p[a] - p[b] == b - a || p[b] - p[a] == b - a) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Column 0 is the most significant digit of the lexicographic key.
    function automatic logic [63:0] lex_key(input logic [63:0] row, input int n, input int w);
        logic [63:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k = (k << 4) | ((row >> (i * w)) & ((64'd1 << w) - 64'd1));
        return k;
    endfunction

    task automatic pulse_start(input logic md);
        @(negedge clk);
        g_mode = md; g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
    endtask

    int r_hs, r_vseen, r_illegal, r_order;
    bit r_tmo;

    task automatic run_search(input int budget);
        logic [63:0] last;
        bit          first;
        first = 1'b1; last = '0;
        r_hs = 0; r_vseen = 0; r_illegal = 0; r_order = 0; r_tmo = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (m_done) begin r_tmo = 1'b0; break; end
            if (m_vld) begin
                r_vseen++;
                if (g_ready) begin
                    r_hs++;
                    if (!legal(m_row, cur_n, cur_w)) r_illegal++;
                    if (!first && lex_key(m_row, cur_n, cur_w) <= last) r_order++;
                    last = lex_key(m_row, cur_n, cur_w);
                    first = 1'b0;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_vld(input int budget);
        r_tmo = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (m_vld) begin r_tmo = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] held;
        int glitch, pre_hs;
        rst_n = 1'b0; g_start = 1'b0; g_mode = 1'b0; g_abort = 1'b0; g_ready = 1'b0;
        select(0, 8, 3);
        #12;
        check("rst_valid", 64'(m_vld), 64'd0);
        check("rst_busy", 64'(m_busy), 64'd0);
        check("rst_done", 64'(m_done), 64'd0);
        check("rst_count", m_cnt, 64'd0);
        check("rst_row", m_row, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // N=8 enumerate all
        g_ready = 1'b1;
        pulse_start(1'b0);
        check("n8_busy_after_start", 64'(m_busy), 64'd1);
        run_search(25000);
        check("n8_timeout", 64'(r_tmo), 64'd0);
        check("n8_handshakes", 64'(r_hs), 64'd92);
        check("n8_count", m_cnt, 64'd92);
        check("n8_done", 64'(m_done), 64'd1);
        check("n8_busy_end", 64'(m_busy), 64'd0);
        check("n8_illegal", 64'(r_illegal), 64'd0);
        check("n8_order", 64'(r_order), 64'd0);

        // N=8 first-solution mode, restarted from DONE
        g_ready = 1'b0;
        pulse_start(1'b1);
        wait_vld(5000);
        check("n8m1_timeout", 64'(r_tmo), 64'd0);
        check("n8m1_row", m_row, pack('{0, 4, 7, 5, 2, 6, 1, 3}, 8, 3));
        g_ready = 1'b1;
        run_search(100);
        check("n8m1_count", m_cnt, 64'd1);
        check("n8m1_done", 64'(m_done), 64'd1);

        // N=4 backpressure
        select(1, 4, 2);
        g_ready = 1'b0;
        pulse_start(1'b0);
        wait_vld(500);
        check("n4_timeout", 64'(r_tmo), 64'd0);
        held = m_row;
        check("n4_row1", m_row, pack('{1, 3, 0, 2, 0, 0, 0, 0}, 4, 2));
        glitch = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_vld || m_row !== held) glitch++;
        end
        check("n4_hold", 64'(glitch), 64'd0);
        check("n4_count_held", m_cnt, 64'd0);
        g_ready = 1'b1;
        @(negedge clk);
        g_ready = 1'b0;
        check("n4_count_one", m_cnt, 64'd1);
        wait_vld(500);
        check("n4_row2", m_row, pack('{2, 0, 3, 1, 0, 0, 0, 0}, 4, 2));
        g_ready = 1'b1;
        run_search(500);
        check("n4_count", m_cnt, 64'd2);
        check("n4_done", 64'(m_done), 64'd1);

        // N=3: no solutions
        select(2, 3, 2);
        pulse_start(1'b0);
        run_search(500);
        check("n3_timeout", 64'(r_tmo), 64'd0);
        check("n3_valid_seen", 64'(r_vseen), 64'd0);
        check("n3_count", m_cnt, 64'd0);
        check("n3_done", 64'(m_done), 64'd1);

        // N=1: single solution {0}
        select(3, 1, 1);
        g_ready = 1'b0;
        pulse_start(1'b0);
        wait_vld(50);
        check("n1_timeout", 64'(r_tmo), 64'd0);
        check("n1_row", m_row, 64'd0);
        g_ready = 1'b1;
        run_search(50);
        check("n1_count", m_cnt, 64'd1);
        check("n1_done", 64'(m_done), 64'd1);

        // 3-bit counter: 4 fits, 10 saturates at 7
        select(4, 6, 3);
        pulse_start(1'b0);
        run_search(5000);
        check("n6_handshakes", 64'(r_hs), 64'd4);
        check("n6_count", m_cnt, 64'd4);
        select(5, 5, 3);
        pulse_start(1'b0);
        run_search(5000);
        check("n5_handshakes", 64'(r_hs), 64'd10);
        check("n5_count_sat", m_cnt, 64'd7);
        check("n5_illegal", 64'(r_illegal), 64'd0);

        // Abort 50 cycles into an N=8 search, then a full run
        select(0, 8, 3);
        pulse_start(1'b0);
        pre_hs = 0;
        for (int i = 0; i < 49; i++) begin
            if (m_vld && g_ready) pre_hs++;
            @(negedge clk);
        end
        g_abort = 1'b1;
        @(negedge clk);
        g_abort = 1'b0;
        check("abort_busy", 64'(m_busy), 64'd0);
        check("abort_done", 64'(m_done), 64'd0);
        check("abort_valid", 64'(m_vld), 64'd0);
        check("abort_count_held", m_cnt, 64'(pre_hs));
        pulse_start(1'b0);
        run_search(25000);
        check("rerun_timeout", 64'(r_tmo), 64'd0);
        check("rerun_count", m_cnt, 64'd92);

        // Abort on the same cycle as a handshake: not counted
        g_ready = 1'b0;
        pulse_start(1'b0);
        wait_vld(5000);
        g_abort = 1'b1; g_ready = 1'b1;
        @(negedge clk);
        g_abort = 1'b0; g_ready = 1'b0;
        check("abort_hs_count", m_cnt, 64'd0);
        check("abort_hs_valid", 64'(m_vld), 64'd0);

        // Reset while in EMIT
        pulse_start(1'b0);
        wait_vld(5000);
        g_ready = 1'b1;
        @(negedge clk);
        g_ready = 1'b0;
        wait_vld(5000);
        check("pre_rst_count", m_cnt, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(m_vld), 64'd0);
        check("mid_rst_busy", 64'(m_busy), 64'd0);
        check("mid_rst_done", 64'(m_done), 64'd0);
        check("mid_rst_count", m_cnt, 64'd0);
        check("mid_rst_row", m_row, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
